// File: rtl/cpu_memory.sv
// 16 x 8-bit program/data memory with a byte-stream loader that holds the CPU in reset
// until LOAD_LEN bytes have been written, then hands the array over to the CPU bus.
module cpu_memory #(
  parameter int unsigned LOAD_LEN = 16,
  parameter logic [7:0]  INIT_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       read,
  input  logic       write,
  input  logic [3:0] address,
  input  logic [7:0] memoryIn,
  output logic [7:0] memoryOut,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       cpu_run,
  output logic       collision
);

  localparam logic [3:0] LastPtr = 4'(LOAD_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic       collision_q, collision_d;
  logic [7:0] mem_q [16];
  logic [7:0] mem_d [16];

  logic load_accept;
  logic cpu_write;

  assign load_accept = (state_q == StLoad) && load_valid;
  assign cpu_write   = (state_q == StRun) && write;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    collision_d = collision_q;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoad;
          ptr_d   = 4'd0;
        end
      end
      StLoad: begin
        if (load_valid) begin
          if (ptr_q == LastPtr) begin
            state_d = StRun;
            ptr_d   = 4'd0;
          end else begin
            ptr_d = ptr_q + 4'd1;
          end
        end
      end
      StRun: begin
        if (read && write) begin
          collision_d = 1'b1;
        end
        // A pending CPU write still lands on the edge that leaves RUN.
        if (load_start) begin
          state_d = StLoad;
          ptr_d   = 4'd0;
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (load_accept) begin
      mem_d[ptr_q] = load_data;
    end
    if (cpu_write) begin
      mem_d[address] = memoryIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= 4'd0;
      collision_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= INIT_VAL;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      collision_q <= collision_d;
      mem_q       <= mem_d;
    end
  end

  // Reads see the registered array, so a same-cycle write returns the old data.
  always_comb begin
    memoryOut = 8'h00;
    if ((state_q == StRun) && read) begin
      memoryOut = mem_q[address];
    end
  end

  assign load_ready = (state_q == StLoad);
  assign cpu_run    = (state_q == StRun);
  assign collision  = collision_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Drives a 16-byte and a 4-byte instance from one stimulus stream and checks both against
// a behavioural model of the loader/RUN rules.
module tb_cpu_memory;

  localparam int MIdle = 0;
  localparam int MLoad = 1;
  localparam int MRun  = 2;

  logic       clk;
  logic       reset, read, write, load_start, load_valid;
  logic [3:0] address;
  logic [7:0] memoryIn, load_data;

  logic [7:0] out16, out4;
  logic       ready16, ready4, run16, run4, col16, col4;

  int checks = 0;
  int passed = 0;

  int         len_m  [2];
  logic [7:0] init_m [2];
  int         st_m   [2];
  int         ptr_m  [2];
  bit         col_m  [2];
  logic [7:0] mem_m  [2][16];

  logic [7:0] image [16];

  cpu_memory #(.LOAD_LEN(16), .INIT_VAL(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .memoryIn  (memoryIn),
    .memoryOut (out16),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(ready16),
    .cpu_run   (run16),
    .collision (col16)
  );

  cpu_memory #(.LOAD_LEN(4), .INIT_VAL(8'h3C)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .read      (read),
    .write     (write),
    .address   (address),
    .memoryIn  (memoryIn),
    .memoryOut (out4),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(ready4),
    .cpu_run   (run4),
    .collision (col4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        st_m[i]  = MIdle;
        ptr_m[i] = 0;
        col_m[i] = 1'b0;
        for (int a = 0; a < 16; a++) mem_m[i][a] = init_m[i];
      end else if (st_m[i] == MIdle) begin
        if (load_start) begin
          st_m[i]  = MLoad;
          ptr_m[i] = 0;
        end
      end else if (st_m[i] == MLoad) begin
        if (load_valid) begin
          mem_m[i][ptr_m[i]] = load_data;
          ptr_m[i] = ptr_m[i] + 1;
          if (ptr_m[i] == len_m[i]) begin
            st_m[i]  = MRun;
            ptr_m[i] = 0;
          end
        end
      end else begin
        if (write) mem_m[i][address] = memoryIn;
        if (read && write) col_m[i] = 1'b1;
        if (load_start) begin
          st_m[i]  = MLoad;
          ptr_m[i] = 0;
        end
      end
    end
  endfunction

  task automatic model_check();
    logic [7:0] exp_out;
    for (int i = 0; i < 2; i++) begin
      exp_out = (st_m[i] == MRun && read) ? mem_m[i][address] : 8'h00;
      chk($sformatf("d%0d_memoryOut", i), (i == 0) ? out16 : out4, exp_out);
      chk($sformatf("d%0d_load_ready", i), {7'd0, (i == 0) ? ready16 : ready4},
          {7'd0, st_m[i] == MLoad});
      chk($sformatf("d%0d_cpu_run", i), {7'd0, (i == 0) ? run16 : run4},
          {7'd0, st_m[i] == MRun});
      chk($sformatf("d%0d_collision", i), {7'd0, (i == 0) ? col16 : col4}, {7'd0, col_m[i]});
    end
  endtask

  // Inputs are set right after an edge; outputs are compared mid-cycle, then the edge advances.
  task automatic step(input bit do_chk = 1'b1);
    #1;
    if (do_chk) model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    reset = 1'b1; read = 1'b0; write = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    address = 4'd0; memoryIn = 8'h00; load_data = 8'h00;
  endtask

  initial begin
    len_m[0] = 16; init_m[0] = 8'h00;
    len_m[1] = 4;  init_m[1] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      st_m[i] = MIdle; ptr_m[i] = 0; col_m[i] = 1'b0;
    end

    // Reset with every bus strobe active; reset must win.
    quiet();
    reset = 1'b0; read = 1'b1; write = 1'b1; load_valid = 1'b1; memoryIn = 8'hFF;
    step(1'b0);
    step();
    quiet();
    read = 1'b1; address = 4'd5;
    #1;
    chk("idle_read_zero", out16, 8'h00);
    chk("idle_ready_low", {7'd0, ready16}, 8'h00);
    step();

    // 16-byte stream 10..1F.
    quiet();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int b = 0; b < 16; b++) begin
      load_data = 8'h10 + 8'(b);
      step();
    end
    quiet();
    read = 1'b1; address = 4'd5;
    #1;
    chk("load16_cpu_run", {7'd0, run16}, 8'h01);
    chk("load16_addr5", out16, 8'h15);
    step();

    // CPU write then read back.
    quiet();
    write = 1'b1; address = 4'd3; memoryIn = 8'h5A;
    step();
    write = 1'b0; read = 1'b1;
    #1;
    chk("write_readback", out16, 8'h5A);
    step();

    // Read/write collision at address 7.
    quiet();
    read = 1'b1; write = 1'b1; address = 4'd7; memoryIn = 8'hEE;
    #1;
    chk("collide_old_data", out16, 8'h17);
    step();
    write = 1'b0;
    #1;
    chk("collide_new_data", out16, 8'hEE);
    chk("collide_flag", {7'd0, col16}, 8'h01);
    step();
    read = 1'b0;
    step();
    step();
    #1;
    chk("collide_sticky", {7'd0, col16}, 8'h01);
    step();

    // Reload from RUN, with a write in the same cycle as load_start.
    quiet();
    load_start = 1'b1; write = 1'b1; address = 4'd9; memoryIn = 8'h99;
    step();
    quiet();
    #1;
    chk("reload_run_low", {7'd0, run16}, 8'h00);
    chk("reload_ready_high", {7'd0, ready16}, 8'h01);
    for (int b = 0; b < 16; b++) begin
      image[b] = 8'($urandom);
      load_valid = 1'b0;
      while ($urandom_range(0, 3) == 0) step();
      load_valid = 1'b1;
      load_data = image[b];
      step();
    end
    quiet();
    for (int a = 0; a < 16; a++) begin
      read = 1'b1; address = 4'(a);
      #1;
      chk($sformatf("reload_addr%0d", a), out16, image[a]);
      step();
    end

    // Reset mid-load, then a restarted load with a valid gap.
    quiet();
    load_start = 1'b1;
    step();
    quiet();
    load_valid = 1'b1; load_data = 8'h61;
    step();
    load_data = 8'h62;
    step();
    reset = 1'b0; load_data = 8'h63;
    step();
    quiet();
    #1;
    chk("midload_reset_ready", {7'd0, ready16}, 8'h00);
    chk("midload_reset_run", {7'd0, run16}, 8'h00);
    load_start = 1'b1;
    step();
    quiet();
    load_valid = 1'b1; load_data = 8'hAA;
    step();
    load_data = 8'hBB;
    step();
    load_valid = 1'b0; load_data = 8'h00;
    step(); step(); step();
    load_valid = 1'b1; load_data = 8'hCC;
    step();
    load_data = 8'hDD;
    step();
    quiet();
    read = 1'b1; address = 4'd2;
    #1;
    chk("len4_run", {7'd0, run4}, 8'h01);
    chk("len4_addr2", out4, 8'hCC);
    step();
    address = 4'd4;
    #1;
    chk("len4_addr4_init", out4, 8'h3C);
    step();
    address = 4'd0;
    #1;
    chk("len4_addr0", out4, 8'hAA);
    step();
    // Finish the 16-byte image; locations 4..15 were cleared by the reset.
    quiet();
    load_valid = 1'b1;
    for (int b = 4; b < 16; b++) begin
      load_data = 8'h40 + 8'(b);
      step();
    end
    quiet();
    read = 1'b1; address = 4'd1;
    #1;
    chk("len16_addr1", out16, 8'hBB);
    step();

    // Random traffic, including occasional resets and reloads.
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 59) != 0);
      load_start = ($urandom_range(0, 24) == 0);
      load_valid = ($urandom_range(0, 2) != 0);
      read       = ($urandom_range(0, 1) == 0);
      write      = ($urandom_range(0, 5) == 0);
      address    = 4'($urandom);
      memoryIn   = 8'($urandom);
      load_data  = 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cpu_memory.md
CPU_MEMORY -- requirements
Module: cpu_memory

Interface
REQ-001 Parameter LOAD_LEN, default 16: number of bytes accepted in LOAD before entering RUN; legal range 1..16.
REQ-002 Parameter INIT_VAL, default 8'h00: value written to every location on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 read  input  1  CPU read strobe.
REQ-006 write  input  1  CPU write strobe.
REQ-007 address  input  4  CPU word address, 16 locations.
REQ-008 memoryIn  input  8  write data from CPU bus.
REQ-009 memoryOut  output  8  read data to CPU bus.
REQ-010 load_start  input  1  request to (re)load the program image.
REQ-011 load_valid  input  1  loader byte valid.
REQ-012 load_data  input  8  loader byte.
REQ-013 load_ready  output  1  loader byte accepted when load_valid&load_ready at a clk edge.
REQ-014 cpu_run  output  1  high only in RUN; drives the CPU reset release externally.
REQ-015 collision  output  1  sticky flag: read and write asserted together in RUN.

Function
REQ-016 Storage SHALL be 16 x 8-bit registers, addressed by address or by the 4-bit load pointer ptr.
REQ-017 FSM states SHALL be IDLE, LOAD, RUN; encoding is free.
REQ-018 IDLE: load_ready=0, cpu_run=0; load_start=1 -> LOAD next cycle with ptr=0.
REQ-019 LOAD: load_ready=1; each accepted byte writes mem[ptr]<=load_data and increments ptr by 1.
REQ-020 LOAD: acceptance with ptr==LOAD_LEN-1 -> RUN next cycle; ptr returns to 0; locations >= LOAD_LEN keep their previous contents.
REQ-021 LOAD: load_valid=0 holds state and ptr indefinitely; load_start is ignored.
REQ-022 RUN: cpu_run=1, load_ready=0; load_valid and load_data are ignored.
REQ-023 RUN read: memoryOut SHALL equal mem[address] combinationally while read=1; 0 latency.
REQ-024 RUN write: write=1 writes mem[address]<=memoryIn at the clk edge; new data is visible from the next cycle.
REQ-025 RUN read and write in the same cycle: the write occurs, memoryOut shows the pre-write data, and collision is set to 1 from the next cycle until reset.
REQ-026 RUN: load_start=1 -> LOAD next cycle, ptr=0, cpu_run=0 from that cycle; a write in the same cycle still completes.
REQ-027 memoryOut SHALL be 8'h00 whenever read=0 or the state is not RUN.
REQ-028 read and write outside RUN SHALL have no effect on memory or collision.
REQ-029 ptr arithmetic SHALL be 4-bit; it never exceeds LOAD_LEN-1.

Reset
REQ-030 reset=0 at a clk edge SHALL force: state=IDLE, ptr=0, all locations=INIT_VAL, load_ready=0, cpu_run=0, collision=0; memoryOut=0.
REQ-031 reset SHALL take priority over every load or CPU transfer in the same cycle, including mid-LOAD and mid-RUN.

Verification
REQ-032 Reset, pulse load_start, then stream bytes 8'h10..8'h1F with load_valid=1 -> 16 transfers; cpu_run=1 on the cycle after the last transfer; with read=1 at address 5, memoryOut=8'h15.
REQ-033 With LOAD_LEN=4, load AA,BB,CC,DD with a 3-cycle load_valid gap after the second byte -> ptr holds during the gap; RUN entered; address 2 reads CC; address 4 reads INIT_VAL.
REQ-034 RUN: write=1, address=3, memoryIn=8'h5A -> next cycle, read of address 3 gives 8'h5A; read during IDLE gives 8'h00.
REQ-035 RUN: read=1 and write=1 at address 7 (old 8'h17, new 8'hEE) -> memoryOut=8'h17 that cycle, 8'hEE next cycle; collision=1 and it stays 1.
REQ-036 Assert reset=0 after 2 of 16 LOAD bytes -> next cycle IDLE, all locations INIT_VAL, load_ready=0; a new load_start restarts at ptr=0.
REQ-037 RUN, pulse load_start -> cpu_run falls next cycle and load_ready=1; reload of 16 bytes overwrites the image and returns to RUN.
